change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/candy_pkg.sv | 38 +++
 rtl/coin_select.sv | 40 ++++
 rtl/change_dispenser.sv | 159 +++++++++++++++
 tb/tb_change_dispenser.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/candy_pkg.sv
// Shared definitions for the candy machine coin path.
// Holds the coin encoding, coin values and the change dispenser state set.
// The coin-acceptor side imports the same coin encoding and values.
package candy_pkg;

    // Coin encoding as seen on the ejector interface.
    typedef enum logic [1:0] {
        COIN_NONE    = 2'b00,
        COIN_NICKEL  = 2'b01,
        COIN_DIME    = 2'b10,
        COIN_QUARTER = 2'b11
    } coin_t;

    // Coin values in cents.
    localparam logic [4:0] NICKEL_VALUE  = 5'd5;
    localparam logic [4:0] DIME_VALUE    = 5'd10;
    localparam logic [4:0] QUARTER_VALUE = 5'd25;

    // Change dispenser state set.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SELECT   = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_DONE     = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    // Value in cents of a coin code; COIN_NONE is worth nothing.
    function automatic logic [4:0] coin_value(input coin_t coin);
        case (coin)
            COIN_NICKEL:  coin_value = NICKEL_VALUE;
            COIN_DIME:    coin_value = DIME_VALUE;
            COIN_QUARTER: coin_value = QUARTER_VALUE;
            default:      coin_value = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/coin_select.sv
// Greedy coin picker (purely combinational).
// Ports:
//   rem        - cents still owed
//   inv_q/d/n  - coins available of each kind
//   pick_valid - a coin can be paid toward rem
//   pick_type  - the largest coin that fits and is in stock
module coin_select
    import candy_pkg::*;
#(
    parameter int AMT_W = 8,
    parameter int INV_W = 6
) (
    input  logic [AMT_W-1:0] rem,
    input  logic [INV_W-1:0] inv_q,
    input  logic [INV_W-1:0] inv_d,
    input  logic [INV_W-1:0] inv_n,
    output logic             pick_valid,
    output coin_t            pick_type
);

    // Largest coin first; a coin is only eligible when it fits and is stocked.
    always_comb begin
        pick_valid = 1'b0;
        pick_type  = COIN_NONE;
        if ((rem >= AMT_W'(QUARTER_VALUE)) && (inv_q != '0)) begin
            pick_valid = 1'b1;
            pick_type  = COIN_QUARTER;
        end else if ((rem >= AMT_W'(DIME_VALUE)) && (inv_d != '0)) begin
            pick_valid = 1'b1;
            pick_type  = COIN_DIME;
        end else if ((rem >= AMT_W'(NICKEL_VALUE)) && (inv_n != '0)) begin
            pick_valid = 1'b1;
            pick_type  = COIN_NICKEL;
        end else begin
            pick_valid = 1'b0;
            pick_type  = COIN_NONE;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays a requested amount with quarters, dimes and nickels
// from a restockable inventory, one coin per ejector handshake.
// Ports:
//   clk, rst                 - clock, async active-high reset
//   req_valid/req_amount     - change request (accepted when req_ready)
//   req_ready                - high only while idle
//   coin_valid/coin_type     - coin offered to the ejector, held until coin_ready
//   coin_ready               - ejector takes the offered coin
//   done/fault               - one-cycle completion / failure pulse
//   shortfall                - unpaid cents, valid with done/fault
//   load, load_q/d/n         - restock (absolute counts), honoured only when idle
//   inv_q/d/n                - current inventory
module change_dispenser
    import candy_pkg::*;
#(
    parameter int AMT_W = 8,
    parameter int INV_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    output logic             coin_valid,
    output logic [1:0]       coin_type,
    input  logic             coin_ready,
    output logic             done,
    output logic             fault,
    output logic [AMT_W-1:0] shortfall,
    input  logic             load,
    input  logic [INV_W-1:0] load_q,
    input  logic [INV_W-1:0] load_d,
    input  logic [INV_W-1:0] load_n,
    output logic [INV_W-1:0] inv_q,
    output logic [INV_W-1:0] inv_d,
    output logic [INV_W-1:0] inv_n
);

    state_t           state_r;
    logic [AMT_W-1:0] rem_r;
    logic [AMT_W-1:0] shortfall_r;
    logic [INV_W-1:0] inv_q_r;
    logic [INV_W-1:0] inv_d_r;
    logic [INV_W-1:0] inv_n_r;
    logic             coin_valid_r;
    coin_t            coin_type_r;
    logic             done_r;
    logic             fault_r;
    logic             req_ready_r;

    logic             pick_valid_s;
    coin_t            pick_type_s;
    logic             misaligned_s;

    coin_select #(
        .AMT_W (AMT_W),
        .INV_W (INV_W)
    ) u_coin_select (
        .rem        (rem_r),
        .inv_q      (inv_q_r),
        .inv_d      (inv_d_r),
        .inv_n      (inv_n_r),
        .pick_valid (pick_valid_s),
        .pick_type  (pick_type_s)
    );

    // rem stays congruent mod 5 while paying, so this only fires for bad requests.
    assign misaligned_s = (rem_r % AMT_W'(NICKEL_VALUE)) != '0;

    // Request sequencing, inventory bookkeeping and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            rem_r        <= '0;
            shortfall_r  <= '0;
            inv_q_r      <= '0;
            inv_d_r      <= '0;
            inv_n_r      <= '0;
            coin_valid_r <= 1'b0;
            coin_type_r  <= COIN_NONE;
            done_r       <= 1'b0;
            fault_r      <= 1'b0;
            req_ready_r  <= 1'b1;
        end else begin
            done_r  <= 1'b0;
            fault_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // Restock lands at the same edge as an acceptance, so SELECT sees it.
                    if (load) begin
                        inv_q_r <= load_q;
                        inv_d_r <= load_d;
                        inv_n_r <= load_n;
                    end
                    if (req_valid && req_ready_r) begin
                        rem_r       <= req_amount;
                        shortfall_r <= '0;
                        req_ready_r <= 1'b0;
                        state_r     <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (misaligned_s) begin
                        fault_r     <= 1'b1;
                        shortfall_r <= rem_r;
                        state_r     <= ST_FAULT;
                    end else if (pick_valid_s) begin
                        coin_valid_r <= 1'b1;
                        coin_type_r  <= pick_type_s;
                        state_r      <= ST_DISPENSE;
                    end else if (rem_r == '0) begin
                        done_r      <= 1'b1;
                        shortfall_r <= rem_r;
                        state_r     <= ST_DONE;
                    end else begin
                        fault_r     <= 1'b1;
                        shortfall_r <= rem_r;
                        state_r     <= ST_FAULT;
                    end
                end
                ST_DISPENSE: begin
                    if (coin_ready) begin
                        rem_r <= rem_r - AMT_W'(coin_value(coin_type_r));
                        case (coin_type_r)
                            COIN_QUARTER: inv_q_r <= inv_q_r - INV_W'(1'b1);
                            COIN_DIME:    inv_d_r <= inv_d_r - INV_W'(1'b1);
                            COIN_NICKEL:  inv_n_r <= inv_n_r - INV_W'(1'b1);
                            default:      inv_n_r <= inv_n_r;
                        endcase
                        coin_valid_r <= 1'b0;
                        coin_type_r  <= COIN_NONE;
                        state_r      <= ST_SELECT;
                    end
                end
                ST_DONE, ST_FAULT: begin
                    req_ready_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    coin_valid_r <= 1'b0;
                    coin_type_r  <= COIN_NONE;
                    req_ready_r  <= 1'b1;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_r;
    assign coin_valid = coin_valid_r;
    assign coin_type  = coin_type_r;
    assign done       = done_r;
    assign fault      = fault_r;
    assign shortfall  = shortfall_r;
    assign inv_q      = inv_q_r;
    assign inv_d      = inv_d_r;
    assign inv_n      = inv_n_r;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser. Expected coin handshakes and
// terminal pulses are queued by each test and matched by a negedge monitor.
module tb_change_dispenser;

    localparam logic [1:0] K_COIN  = 2'd0;
    localparam logic [1:0] K_DONE  = 2'd1;
    localparam logic [1:0] K_FAULT = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [1:0] ctype;
        logic [7:0] sf;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic [7:0] req_amount;
    logic       req_ready;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       coin_ready;
    logic       done;
    logic       fault;
    logic [7:0] shortfall;
    logic       load;
    logic [5:0] load_q, load_d, load_n;
    logic [5:0] inv_q, inv_d, inv_n;

    int   assertions = 0;
    int   failures   = 0;
    int   term_count = 0;
    exp_t sb[$];
    exp_t mon_e;

    change_dispenser #(.AMT_W(8), .INV_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_amount (req_amount),
        .req_ready  (req_ready),
        .coin_valid (coin_valid),
        .coin_type  (coin_type),
        .coin_ready (coin_ready),
        .done       (done),
        .fault      (fault),
        .shortfall  (shortfall),
        .load       (load),
        .load_q     (load_q),
        .load_d     (load_d),
        .load_n     (load_n),
        .inv_q      (inv_q),
        .inv_d      (inv_d),
        .inv_n      (inv_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every coin handshake and terminal pulse pops one entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (!coin_valid) begin
                assertions++;
                if (coin_type !== 2'b00) begin
                    failures++;
                    $display("FAIL idle_coin_type: got %b, expected 00", coin_type);
                end
            end
            if (coin_valid && coin_ready) begin
                assertions++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL coin_unexpected: got coin %b, expected no coin", coin_type);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.kind !== K_COIN || coin_type !== mon_e.ctype) begin
                        failures++;
                        $display("FAIL coin_order: got coin %b, expected kind %0d coin %b", coin_type, mon_e.kind, mon_e.ctype);
                    end
                end
            end
            if (done || fault) begin
                term_count++;
                assertions++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL term_unexpected: got done=%b fault=%b, expected nothing", done, fault);
                end else begin
                    mon_e = sb.pop_front();
                    if ((done && fault) || (done && mon_e.kind !== K_DONE) ||
                        (fault && mon_e.kind !== K_FAULT) || shortfall !== mon_e.sf) begin
                        failures++;
                        $display("FAIL term_result: got done=%b fault=%b shortfall=%0d, expected kind %0d shortfall %0d", done, fault, shortfall, mon_e.kind, mon_e.sf);
                    end
                end
            end
        end
    end

    task automatic push_coin(input logic [1:0] t);
        exp_t e;
        e.kind = K_COIN; e.ctype = t; e.sf = 8'd0;
        sb.push_back(e);
    endtask

    task automatic push_end(input logic [1:0] k, input logic [7:0] sf);
        exp_t e;
        e.kind = k; e.ctype = 2'b00; e.sf = sf;
        sb.push_back(e);
    endtask

    // Reference greedy payout; queues the expected events and updates model stock.
    task automatic model_push(input int amt, inout int q, inout int d, inout int n);
        int rem;
        rem = amt;
        if (amt % 5 != 0) begin
            push_end(K_FAULT, 8'(amt));
            return;
        end
        forever begin
            if (rem >= 25 && q > 0) begin push_coin(2'b11); rem -= 25; q--; end
            else if (rem >= 10 && d > 0) begin push_coin(2'b10); rem -= 10; d--; end
            else if (rem >= 5 && n > 0) begin push_coin(2'b01); rem -= 5; n--; end
            else break;
        end
        push_end(rem == 0 ? K_DONE : K_FAULT, 8'(rem));
    endtask

    // All drive tasks start and end at posedge + 1.
    task automatic do_load(input logic [5:0] q, input logic [5:0] d, input logic [5:0] n);
        load = 1'b1; load_q = q; load_d = d; load_n = n;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic accept(input logic [7:0] amt, input bit with_load,
                          input logic [5:0] q, input logic [5:0] d, input logic [5:0] n);
        int i;
        i = 0;
        while (!req_ready && i < 50) begin @(posedge clk); #1; i++; end
        assertions++;
        if (i >= 50) begin
            failures++;
            $display("FAIL accept_ready: got req_ready=%b after 50 cycles, expected 1", req_ready);
        end
        req_valid = 1'b1; req_amount = amt;
        load = with_load; load_q = q; load_d = d; load_n = n;
        @(posedge clk); #1;
        req_valid = 1'b0; load = 1'b0;
    endtask

    task automatic wait_term(input int start, input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (term_count != start) begin seen = 1'b1; break; end
        end
        @(posedge clk); #1;
        assertions++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_timeout: got no done/fault in %0d cycles, expected one", name, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_amount = 8'd0; coin_ready = 1'b1;
        load = 1'b0; load_q = 6'd0; load_d = 6'd0; load_n = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        assertions++;
        if (coin_valid !== 1'b0 || coin_type !== 2'b00 || done !== 1'b0 || fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got cv=%b ct=%b done=%b fault=%b, expected 0 00 0 0", coin_valid, coin_type, done, fault);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        assertions++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b, expected 1", req_ready);
        end
        assertions++;
        if (inv_q !== 6'd0 || inv_d !== 6'd0 || inv_n !== 6'd0 || shortfall !== 8'd0) begin
            failures++;
            $display("FAIL reset_state: got inv %0d/%0d/%0d sf %0d, expected 0/0/0 sf 0", inv_q, inv_d, inv_n, shortfall);
        end
    endtask

    task automatic test_basic();
        int t0;
        do_load(6'd2, 6'd2, 6'd2);
        push_coin(2'b11); push_coin(2'b10); push_coin(2'b01); push_end(K_DONE, 8'd0);
        t0 = term_count;
        accept(8'd40, 1'b0, 6'd0, 6'd0, 6'd0);
        @(negedge clk);
        assertions++;
        if (coin_valid !== 1'b0) begin failures++; $display("FAIL basic_lat_c1: got cv=%b, expected 0", coin_valid); end
        @(negedge clk);
        assertions++;
        if (coin_valid !== 1'b1 || coin_type !== 2'b11) begin failures++; $display("FAIL basic_lat_c2: got cv=%b ct=%b, expected 1 11", coin_valid, coin_type); end
        @(negedge clk);
        assertions++;
        if (coin_valid !== 1'b0) begin failures++; $display("FAIL basic_lat_c3: got cv=%b, expected 0", coin_valid); end
        @(negedge clk);
        assertions++;
        if (coin_valid !== 1'b1 || coin_type !== 2'b10) begin failures++; $display("FAIL basic_lat_c4: got cv=%b ct=%b, expected 1 10", coin_valid, coin_type); end
        wait_term(t0, 40, "basic");
        assertions++;
        if (inv_q !== 6'd1 || inv_d !== 6'd1 || inv_n !== 6'd1) begin
            failures++;
            $display("FAIL basic_inv: got %0d/%0d/%0d, expected 1/1/1", inv_q, inv_d, inv_n);
        end
    endtask

    task automatic test_greedy_fault();
        int t0;
        do_load(6'd1, 6'd3, 6'd0);
        push_coin(2'b11); push_end(K_FAULT, 8'd5);
        t0 = term_count;
        accept(8'd30, 1'b0, 6'd0, 6'd0, 6'd0);
        wait_term(t0, 40, "greedy");
        assertions++;
        if (inv_q !== 6'd0 || inv_d !== 6'd3 || inv_n !== 6'd0) begin
            failures++;
            $display("FAIL greedy_inv: got %0d/%0d/%0d, expected 0/3/0", inv_q, inv_d, inv_n);
        end
    endtask

    task automatic test_zero_and_odd();
        int t0;
        push_end(K_DONE, 8'd0);
        t0 = term_count;
        accept(8'd0, 1'b0, 6'd0, 6'd0, 6'd0);
        @(negedge clk);
        assertions++;
        if (done !== 1'b0 || coin_valid !== 1'b0) begin failures++; $display("FAIL zero_c1: got done=%b cv=%b, expected 0 0", done, coin_valid); end
        @(negedge clk);
        assertions++;
        if (done !== 1'b1 || coin_valid !== 1'b0) begin failures++; $display("FAIL zero_c2: got done=%b cv=%b, expected 1 0", done, coin_valid); end
        wait_term(t0, 10, "zero");
        push_end(K_FAULT, 8'd17);
        t0 = term_count;
        accept(8'd17, 1'b0, 6'd0, 6'd0, 6'd0);
        wait_term(t0, 20, "odd");
        assertions++;
        if (inv_q !== 6'd0 || inv_d !== 6'd3 || inv_n !== 6'd0) begin
            failures++;
            $display("FAIL odd_inv: got %0d/%0d/%0d, expected 0/3/0", inv_q, inv_d, inv_n);
        end
    endtask

    task automatic test_backpressure();
        int t0;
        do_load(6'd1, 6'd0, 6'd0);
        coin_ready = 1'b0;
        push_coin(2'b11); push_end(K_DONE, 8'd0);
        t0 = term_count;
        accept(8'd25, 1'b0, 6'd0, 6'd0, 6'd0);
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            assertions++;
            if (coin_valid !== 1'b1 || coin_type !== 2'b11) begin
                failures++;
                $display("FAIL bp_hold_%0d: got cv=%b ct=%b, expected 1 11", c, coin_valid, coin_type);
            end
        end
        @(posedge clk); #1;
        coin_ready = 1'b1;
        @(negedge clk);
        assertions++;
        if (coin_valid !== 1'b1 || coin_type !== 2'b11) begin
            failures++;
            $display("FAIL bp_hold_3: got cv=%b ct=%b, expected 1 11", coin_valid, coin_type);
        end
        wait_term(t0, 20, "bp");
        assertions++;
        if (inv_q !== 6'd0) begin failures++; $display("FAIL bp_inv_q: got %0d, expected 0", inv_q); end
    endtask

    task automatic test_reset_mid();
        int  t0;
        bit  seen;
        bit  pulse;
        do_load(6'd2, 6'd0, 6'd0);
        coin_ready = 1'b0;
        t0 = term_count;
        accept(8'd50, 1'b0, 6'd0, 6'd0, 6'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (coin_valid) begin seen = 1'b1; break; end
        end
        assertions++;
        if (!seen) begin failures++; $display("FAIL rmid_offer: got no coin_valid, expected 1"); end
        #1 rst = 1'b1;
        #1;
        assertions++;
        if (coin_valid !== 1'b0 || coin_type !== 2'b00) begin
            failures++;
            $display("FAIL rmid_async: got cv=%b ct=%b, expected 0 00", coin_valid, coin_type);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        coin_ready = 1'b1;
        assertions++;
        if (req_ready !== 1'b1 || inv_q !== 6'd0 || inv_d !== 6'd0 || inv_n !== 6'd0) begin
            failures++;
            $display("FAIL rmid_state: got ready=%b inv %0d/%0d/%0d, expected 1 0/0/0", req_ready, inv_q, inv_d, inv_n);
        end
        pulse = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || fault || coin_valid) pulse = 1'b1;
        end
        @(posedge clk); #1;
        assertions++;
        if (pulse || term_count != t0) begin
            failures++;
            $display("FAIL rmid_quiet: got activity=%b terms=%0d, expected 0 %0d", pulse, term_count, t0);
        end
    endtask

    task automatic test_load_rules();
        int t0;
        do_load(6'd1, 6'd1, 6'd1);
        coin_ready = 1'b0;
        push_coin(2'b10); push_end(K_DONE, 8'd0);
        t0 = term_count;
        accept(8'd10, 1'b0, 6'd0, 6'd0, 6'd0);
        @(negedge clk);
        @(posedge clk); #1;
        load = 1'b1; load_q = 6'd5; load_d = 6'd5; load_n = 6'd5;
        repeat (2) @(posedge clk);
        #1;
        load = 1'b0;
        coin_ready = 1'b1;
        wait_term(t0, 20, "ldbusy");
        assertions++;
        if (inv_q !== 6'd1 || inv_d !== 6'd0 || inv_n !== 6'd1) begin
            failures++;
            $display("FAIL ldbusy_inv: got %0d/%0d/%0d, expected 1/0/1", inv_q, inv_d, inv_n);
        end
        push_coin(2'b10); push_coin(2'b10); push_end(K_DONE, 8'd0);
        t0 = term_count;
        accept(8'd20, 1'b1, 6'd0, 6'd2, 6'd0);
        wait_term(t0, 20, "ldsame");
        assertions++;
        if (inv_q !== 6'd0 || inv_d !== 6'd0 || inv_n !== 6'd0) begin
            failures++;
            $display("FAIL ldsame_inv: got %0d/%0d/%0d, expected 0/0/0", inv_q, inv_d, inv_n);
        end
    endtask

    task automatic test_back_to_back();
        int t0, mq, md, mn, amt;
        logic [5:0] lq, ld, ln;
        for (int it = 0; it < 8; it++) begin
            lq = 6'($urandom_range(0, 3));
            ld = 6'($urandom_range(0, 3));
            ln = 6'($urandom_range(0, 3));
            mq = int'(lq); md = int'(ld); mn = int'(ln);
            amt = int'($urandom_range(0, 24)) * 5;
            if (it % 4 == 3) amt = amt + int'($urandom_range(1, 4));
            model_push(amt, mq, md, mn);
            t0 = term_count;
            accept(8'(amt), 1'b1, lq, ld, ln);
            wait_term(t0, 100, "b2b");
            assertions++;
            if (inv_q !== 6'(mq) || inv_d !== 6'(md) || inv_n !== 6'(mn)) begin
                failures++;
                $display("FAIL b2b_inv_%0d: got %0d/%0d/%0d, expected %0d/%0d/%0d", it, inv_q, inv_d, inv_n, mq, md, mn);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_greedy_fault();
        test_zero_and_odd();
        test_backpressure();
        test_reset_mid();
        test_load_rules();
        test_back_to_back();
        repeat (2) @(posedge clk);
        #1;
        assertions++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
